rr_resource_arbiter: RTL

- Round-robin arbiter that shares one single-ported resource (e.g. a frame/sprite memory port or a sound channel) among NUM_REQ requesters.
- Each requester holds `req` high for as long as it wants ownership.
- The arbiter issues a registered one-hot grant and rotates priority so that no requester starves.
- Sits between the game-logic requesters and the shared resource's mux select.

---
 rtl/arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 33 +++
 rtl/rr_resource_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin resource arbiter.
// The hold-timeout feature is compiled in with the ARB_TIMEOUT_EN macro.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  localparam int ARB_NUM_REQ_DEF  = 4;
  localparam int ARB_MAX_HOLD_DEF = 64;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans req (with mask bits removed)
// starting at ptr, wrapping modulo NUM_REQ; the first set bit wins.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic [NUM_REQ-1:0] mask,
  output logic               found,
  output logic [ID_W-1:0]    winner
);

  logic [NUM_REQ-1:0] eff_req;

  assign eff_req = req & ~mask;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && eff_req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter granting one shared resource to NUM_REQ requesters.
// Optional hold timeout is compiled in with the ARB_TIMEOUT_EN macro.
module rr_resource_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = ARB_NUM_REQ_DEF,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic               timeout,
  output arb_state_t         dbg_state
);

  arb_state_t         state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [ID_W-1:0]    gnt_id_q;
  logic [ID_W-1:0]    ptr_q;
  logic               timeout_q;

  logic               owner_held;
  logic               hold_expired;
  logic               release_own;
  logic               revoke;
  logic               take_grant;
  logic [NUM_REQ-1:0] pick_mask;
  logic               pick_found;
  logic [ID_W-1:0]    pick_winner;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]    next_ptr;

  assign owner_held = |(req & gnt_q);

  // Masking the owner only changes the result on a timeout revoke; on a
  // normal hand-off the owner's req bit is already low.
  assign pick_mask = (state_q == OWN) ? gnt_q : '0;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .mask   (pick_mask),
    .found  (pick_found),
    .winner (pick_winner)
  );

  assign release_own = (state_q == OWN) && (!owner_held || hold_expired);
  assign revoke      = (state_q == OWN) && owner_held && hold_expired;
  assign take_grant  = pick_found && ((state_q == IDLE) || release_own);
  assign pick_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_winner;
  assign next_ptr    = (pick_winner == ID_W'(NUM_REQ-1)) ? '0 : pick_winner + ID_W'(1);

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HOLD_W-1:0] hold_cnt_q;

  assign hold_expired = (hold_cnt_q == HOLD_W'(MAX_HOLD-1));

  always_ff @(posedge clk) begin
    if (rst || take_grant) begin
      hold_cnt_q <= '0;
    end else if (state_q == OWN) begin
      hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
    end
  end
`else
  assign hold_expired = 1'b0;

  // MAX_HOLD only sizes the hold counter, which this build leaves out.
  if (MAX_HOLD < 1) begin : g_no_hold_limit
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= revoke;
      if (take_grant) begin
        state_q  <= OWN;
        gnt_q    <= pick_onehot;
        gnt_id_q <= pick_winner;
        ptr_q    <= next_ptr;
      end else if (release_own) begin
        state_q <= IDLE;
        gnt_q   <= '0;
      end
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = (state_q == OWN);
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule
